sc_lane_scheduler: RTL and testbench

Game-level sequencer for the Frogger datapath. Owns the game state (idle, running, paused, hit, level won, game over), the life and level counters, and a per-lane movement scheduler. It issues one-cycle shift commands to each traffic-lane shift register, using the same shift-select encoding as the frog point register. It also issues load/clear strobes that re-initialise the lanes and the frog on start, hit and level change. It sits between the button/collision logic and the lane register bank.

---
 rtl/sc_frogger_pkg.sv | 29 ++
 rtl/sc_lane_divider.sv | 28 ++
 rtl/sc_lane_scheduler.sv | 148 ++++++++++++++
 tb/tb_sc_lane_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_frogger_pkg.sv
// Shared Frogger types and constants: game state, shift-select codes, life/level limits,
// and the per-lane movement period helper.
package sc_frogger_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StPause,
    StHit,
    StWin,
    StOver
  } scState_e;

  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_HOLD  = 2'b11;

  localparam logic [1:0] LIVES_INIT = 2'd3;
  localparam logic [2:0] LEVEL_MAX  = 3'd7;

  // Ticks between moves for a lane: max(1, lane + 2 - level); higher lanes are slower.
  function automatic logic [3:0] lanePeriod(input int unsigned lane, input logic [2:0] level);
    logic signed [4:0] p;
    p = $signed(5'(lane + 2)) - $signed({2'b00, level});
    return (p < 5'sd1) ? 4'd1 : p[3:0];
  endfunction

endpackage

// File: rtl/sc_lane_divider.sv
// Per-lane tick divider: counts base ticks down from the lane period and flags the tick
// on which the lane should move. The strobe is combinational; the scheduler registers it.
module sc_lane_divider (
  input  logic       clk,
  input  logic       resetInLow,
  input  logic       load,
  input  logic       tick,
  input  logic       freeze,
  input  logic [3:0] period,
  output logic       strobe
);

  logic [3:0] countQ;

  assign strobe = tick && !freeze && !load && (countQ == 4'd1);

  // Down-counter: reload on load or on expiry, hold while frozen.
  always_ff @(posedge clk or negedge resetInLow) begin
    if (!resetInLow) begin
      countQ <= 4'd0;
    end else if (load) begin
      countQ <= period;
    end else if (tick && !freeze) begin
      countQ <= (countQ == 4'd1) ? period : countQ - 4'd1;
    end
  end

endmodule

// File: rtl/sc_lane_scheduler.sv
// Frogger game sequencer: game FSM, lives/level, base-tick prescaler and per-lane movement
// scheduler. Optional pause support is compiled in with SC_LANESCHEDULER_PAUSE_EN.
module sc_lane_scheduler
  import sc_frogger_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned TICK_PERIOD = 2_500_000,
  parameter int unsigned CNT_W       = 22
) (
  input  logic                   SC_LANESCHEDULER_CLOCK_50,
  input  logic                   SC_LANESCHEDULER_RESET_InLow,
  input  logic                   SC_LANESCHEDULER_startButton_InLow,
  input  logic                   SC_LANESCHEDULER_pauseButton_InLow,
  input  logic                   SC_LANESCHEDULER_collision_InLow,
  input  logic                   SC_LANESCHEDULER_goal_InLow,
  output logic [2*NUM_LANES-1:0] SC_LANESCHEDULER_laneShiftSelection_Out,
  output logic                   SC_LANESCHEDULER_laneLoad_OutLow,
  output logic                   SC_LANESCHEDULER_frogClear_OutLow,
  output logic [2:0]             SC_LANESCHEDULER_level_Out,
  output logic [1:0]             SC_LANESCHEDULER_lives_Out,
  output logic                   SC_LANESCHEDULER_gameOver_Out
);

  localparam logic [CNT_W-1:0] TickLast = CNT_W'(TICK_PERIOD - 1);

  logic clk, rstN;
  assign clk  = SC_LANESCHEDULER_CLOCK_50;
  assign rstN = SC_LANESCHEDULER_RESET_InLow;

  scState_e stateQ, stateD;
  logic startPrevQ, startEdge;
  logic [CNT_W-1:0] prescalerQ;
  logic tick, pauseReq, eventTake;
  logic [1:0] livesQ, livesD;
  logic [2:0] levelQ, levelD;
  logic [NUM_LANES-1:0] laneStrobe;
  logic [2*NUM_LANES-1:0] laneShiftQ, laneShiftD;
  logic loadQ, loadD;
  logic gameOverQ, gameOverD;

  assign startEdge = startPrevQ && !SC_LANESCHEDULER_startButton_InLow;

`ifdef SC_LANESCHEDULER_PAUSE_EN
  assign pauseReq = !SC_LANESCHEDULER_pauseButton_InLow;
`else
  assign pauseReq = 1'b0;
`endif

  // Any RUN event suppresses the strobes that would otherwise be issued this cycle.
  assign eventTake = (stateQ == StRun) && (!SC_LANESCHEDULER_collision_InLow ||
                     !SC_LANESCHEDULER_goal_InLow || pauseReq);
  assign tick      = (stateQ == StRun) && (prescalerQ == TickLast);

  // State register and start-button history.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ     <= StIdle;
      startPrevQ <= 1'b1;
    end else begin
      stateQ     <= stateD;
      startPrevQ <= SC_LANESCHEDULER_startButton_InLow;
    end
  end

  // Next-state logic; RUN priority is collision, then goal, then pause.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle, StOver: if (startEdge) stateD = StLoad;
      StLoad:         stateD = StRun;
      StRun: begin
        if (!SC_LANESCHEDULER_collision_InLow) stateD = StHit;
        else if (!SC_LANESCHEDULER_goal_InLow) stateD = StWin;
        else if (pauseReq)                     stateD = StPause;
      end
      StPause:        if (SC_LANESCHEDULER_pauseButton_InLow) stateD = StRun;
      StHit:          stateD = (livesQ == 2'd1) ? StOver : StLoad;
      StWin:          stateD = StLoad;
      default:        stateD = StIdle;
    endcase
  end

  // Output next values: lane codes from divider strobes, lives/level updates, load strobe.
  always_comb begin
    livesD = livesQ;
    levelD = levelQ;
    for (int i = 0; i < NUM_LANES; i++) begin
      laneShiftD[2*i +: 2] = (laneStrobe[i] && !eventTake) ?
                             (((i % 2) == 0) ? SHIFT_RIGHT : SHIFT_LEFT) : SHIFT_HOLD;
    end
    if ((stateQ == StIdle || stateQ == StOver) && startEdge) begin
      livesD = LIVES_INIT;
      levelD = 3'd0;
    end
    if (stateQ == StHit) livesD = livesQ - 2'd1;
    if (stateQ == StWin && levelQ != LEVEL_MAX) levelD = levelQ + 3'd1;
    loadD     = (stateD != StLoad);
    gameOverD = (stateD == StOver);
  end

  // Registered outputs and game counters.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      laneShiftQ <= '1;
      loadQ      <= 1'b1;
      livesQ     <= LIVES_INIT;
      levelQ     <= 3'd0;
      gameOverQ  <= 1'b0;
    end else begin
      laneShiftQ <= laneShiftD;
      loadQ      <= loadD;
      livesQ     <= livesD;
      levelQ     <= levelD;
      gameOverQ  <= gameOverD;
    end
  end

  // Base-tick prescaler: cleared in LOAD, counts only in RUN, frozen elsewhere.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      prescalerQ <= '0;
    end else if (stateQ == StLoad) begin
      prescalerQ <= '0;
    end else if (stateQ == StRun) begin
      prescalerQ <= tick ? '0 : prescalerQ + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    sc_lane_divider uDivider (
      .clk       (clk),
      .resetInLow(rstN),
      .load      (stateQ == StLoad),
      .tick      (tick),
      .freeze    (stateQ == StPause),
      .period    (lanePeriod(i, levelQ)),
      .strobe    (laneStrobe[i])
    );
  end

  assign SC_LANESCHEDULER_laneShiftSelection_Out = laneShiftQ;
  assign SC_LANESCHEDULER_laneLoad_OutLow        = loadQ;
  assign SC_LANESCHEDULER_frogClear_OutLow       = loadQ;
  assign SC_LANESCHEDULER_level_Out              = levelQ;
  assign SC_LANESCHEDULER_lives_Out              = livesQ;
  assign SC_LANESCHEDULER_gameOver_Out           = gameOverQ;

endmodule

// File: tb/tb_sc_lane_scheduler.sv
// Directed bench for sc_lane_scheduler with TICK_PERIOD=4, NUM_LANES=4.
module tb_sc_lane_scheduler;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic start = 1'b1, pause = 1'b1, coll = 1'b1, goal = 1'b1;
  logic [7:0] lanes;
  logic laneLoad, frogClear, gameOver;
  logic [2:0] level;
  logic [1:0] lives;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sc_lane_scheduler #(
    .NUM_LANES  (4),
    .TICK_PERIOD(4),
    .CNT_W      (3)
  ) dut (
    .SC_LANESCHEDULER_CLOCK_50              (clk),
    .SC_LANESCHEDULER_RESET_InLow           (rstN),
    .SC_LANESCHEDULER_startButton_InLow     (start),
    .SC_LANESCHEDULER_pauseButton_InLow     (pause),
    .SC_LANESCHEDULER_collision_InLow       (coll),
    .SC_LANESCHEDULER_goal_InLow            (goal),
    .SC_LANESCHEDULER_laneShiftSelection_Out(lanes),
    .SC_LANESCHEDULER_laneLoad_OutLow       (laneLoad),
    .SC_LANESCHEDULER_frogClear_OutLow      (frogClear),
    .SC_LANESCHEDULER_level_Out             (level),
    .SC_LANESCHEDULER_lives_Out             (lives),
    .SC_LANESCHEDULER_gameOver_Out          (gameOver)
  );

  // Expected lane vector d cycles after the prescaler first reads 0 (first RUN cycle).
  function automatic logic [7:0] exp_lanes(input int d, input int lvl);
    logic [7:0] v;
    int p;
    v = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      p = i + 2 - lvl;
      if (p < 1) p = 1;
      if (d > 0 && (d % 4) == 0 && ((d / 4) % p) == 0)
        v[2*i +: 2] = ((i % 2) == 0) ? 2'b10 : 2'b01;
    end
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    start = 1'b1; pause = 1'b1; coll = 1'b1; goal = 1'b1;
    @(negedge clk);
    rstN = 1'b0;
    step(2);
    rstN = 1'b1;
    step(2);
  endtask

  // Start edge in the current cycle t; returns in LOAD cycle t+1; RUN starts at t+2.
  task automatic start_game(output int run0);
    start = 1'b0;
    run0 = cyc + 2;
    step(1);
    start = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (lanes !== 8'hFF) begin errors++; $display("FAIL reset_lanes got=%h exp=ff", lanes); end
    checks++; if (laneLoad !== 1'b1 || frogClear !== 1'b1) begin
      errors++; $display("FAIL reset_load got=%b%b exp=11", laneLoad, frogClear); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives got=%0d exp=3", lives); end
    checks++; if (gameOver !== 1'b0) begin errors++; $display("FAIL reset_gameover got=%b exp=0", gameOver); end
  endtask

  task automatic test_start_timing();
    int run0;
    do_reset();
    step(3);
    checks++; if (laneLoad !== 1'b1) begin errors++; $display("FAIL pre_start_load got=%b exp=1", laneLoad); end
    start_game(run0);
    checks++; if (laneLoad !== 1'b0 || frogClear !== 1'b0) begin
      errors++; $display("FAIL load_cycle got=%b%b exp=00", laneLoad, frogClear); end
    step(1);
    checks++; if (laneLoad !== 1'b1) begin errors++; $display("FAIL load_width got=%b exp=1", laneLoad); end
    for (int n = 0; n < 36; n++) begin
      checks++;
      if (lanes !== exp_lanes(cyc - run0, 0)) begin
        errors++; $display("FAIL lvl0_lanes d=%0d got=%h exp=%h", cyc - run0, lanes, exp_lanes(cyc - run0, 0));
      end
      step(1);
    end
  endtask

  task automatic test_start_held();
    int loads;
    do_reset();
    loads = 0;
    start = 1'b0;
    for (int n = 0; n < 50; n++) begin
      step(1);
      if (laneLoad === 1'b0) loads++;
    end
    start = 1'b1;
    step(1);
    checks++; if (loads !== 1) begin errors++; $display("FAIL held_start_loads got=%0d exp=1", loads); end
  endtask

  task automatic test_collisions();
    int run0, loads, bad;
    do_reset();
    start_game(run0);
    loads = 0;
    for (int k = 1; k <= 3; k++) begin
      step(6);
      coll = 1'b0;
      step(1);
      coll = 1'b1;
      checks++; if (lanes !== 8'hFF) begin errors++; $display("FAIL hit_lanes k=%0d got=%h exp=ff", k, lanes); end
      step(1);
      if (laneLoad === 1'b0) loads++;
      checks++; if (lives !== 2'(3 - k)) begin errors++; $display("FAIL hit_lives k=%0d got=%0d exp=%0d", k, lives, 3 - k); end
    end
    checks++; if (gameOver !== 1'b1) begin errors++; $display("FAIL over_flag got=%b exp=1", gameOver); end
    checks++; if (loads !== 2) begin errors++; $display("FAIL hit_loads got=%0d exp=2", loads); end
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      step(1);
      if (lanes !== 8'hFF || gameOver !== 1'b1 || laneLoad !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL over_hold bad_cycles=%0d exp=0", bad); end
    coll = 1'b0; goal = 1'b0;
    step(2);
    coll = 1'b1; goal = 1'b1;
    step(1);
    checks++; if (lives !== 2'd0 || level !== 3'd0) begin
      errors++; $display("FAIL over_ignore lives=%0d level=%0d exp=0,0", lives, level); end
    start_game(run0);
    checks++; if (laneLoad !== 1'b0 || lives !== 2'd3 || gameOver !== 1'b0) begin
      errors++; $display("FAIL restart got load=%b lives=%0d over=%b exp=0,3,0", laneLoad, lives, gameOver); end
  endtask

  task automatic test_goals();
    int run0;
    do_reset();
    start_game(run0);
    for (int g = 1; g <= 8; g++) begin
      step(5);
      goal = 1'b0;
      step(1);
      goal = 1'b1;
      step(1);
      checks++;
      if (level !== 3'((g > 7) ? 7 : g) || lives !== 2'd3 || laneLoad !== 1'b0) begin
        errors++; $display("FAIL goal g=%0d got level=%0d lives=%0d load=%b exp=%0d,3,0",
                           g, level, lives, laneLoad, (g > 7) ? 7 : g);
      end
    end
    run0 = cyc + 1;
    for (int n = 0; n < 20; n++) begin
      step(1);
      checks++;
      if (lanes !== exp_lanes(cyc - run0, 7)) begin
        errors++; $display("FAIL lvl7_lanes d=%0d got=%h exp=%h", cyc - run0, lanes, exp_lanes(cyc - run0, 7));
      end
    end
  endtask

  task automatic test_simultaneous();
    int run0;
    do_reset();
    start_game(run0);
    step(4);
    goal = 1'b0;
    step(1);
    goal = 1'b1;
    step(1);
    run0 = cyc + 1;
    step(5);
    checks++; if (lanes !== 8'hFE) begin errors++; $display("FAIL lvl1_strobe got=%h exp=fe", lanes); end
    step(3);
    coll = 1'b0; goal = 1'b0;
    step(1);
    coll = 1'b1; goal = 1'b1;
    checks++; if (lanes !== 8'hFF) begin errors++; $display("FAIL event_no_strobe got=%h exp=ff", lanes); end
    step(1);
    checks++; if (lives !== 2'd2 || level !== 3'd1 || laneLoad !== 1'b0) begin
      errors++; $display("FAIL both_events got lives=%0d level=%0d load=%b exp=2,1,0", lives, level, laneLoad); end
  endtask

  task automatic test_pause();
    int run0, pc, m;
    logic [7:0] e;
    do_reset();
    start_game(run0);
    step(10);
    pc = cyc;
    pause = 1'b0;
    for (int n = 1; n <= 130; n++) begin
      step(1);
      if (n == 100) pause = 1'b1;
`ifdef SC_LANESCHEDULER_PAUSE_EN
      if (cyc > pc && cyc <= pc + 100) e = 8'hFF;
      else begin
        m = (cyc > pc + 100) ? cyc - 100 : cyc;
        e = exp_lanes(m - run0, 0);
      end
`else
      m = cyc;
      e = exp_lanes(m - run0, 0);
`endif
      checks++;
      if (lanes !== e) begin errors++; $display("FAIL pause_lanes n=%0d got=%h exp=%h", n, lanes, e); end
    end
  endtask

  task automatic test_midgame_reset();
    int run0;
    do_reset();
    start_game(run0);
    step(9);
    checks++; if (lanes !== 8'hFE) begin errors++; $display("FAIL pre_reset_strobe got=%h exp=fe", lanes); end
    #1 rstN = 1'b0;
    #1;
    checks++; if (lanes !== 8'hFF || laneLoad !== 1'b1 || lives !== 2'd3) begin
      errors++; $display("FAIL async_reset got lanes=%h load=%b lives=%0d exp=ff,1,3", lanes, laneLoad, lives); end
    rstN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start_timing();
    test_start_held();
    test_collisions();
    test_goals();
    test_simultaneous();
    test_pause();
    test_midgame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
